// File: rtl/score4_pkg.sv
// Shared types and defaults for the Score 4 game core.
package score4_pkg;

   localparam int DEF_COLS   = 7;
   localparam int DEF_ROWS   = 6;
   localparam int DEF_CELL_W = 2;
   localparam int EMPTY      = 0;

   typedef enum logic [1:0] {
      IDLE,
      FALL,
      LAND
   } state_t;

endpackage

// File: rtl/onehot_column_decode.sv
// One-hot column select to binary index.
// valid is high only when exactly one bit is set.
module onehot_column_decode #(
   parameter  int COLS = 7,
   localparam int IW   = (COLS > 1) ? $clog2(COLS) : 1
) (
   input  logic [COLS-1:0] onehot,
   output logic [IW-1:0]   index,
   output logic            valid
);

   always_comb begin
      index = '0;
      for (int i = 0; i < COLS; i++) begin
         if (onehot[i]) index = index | IW'(i);
      end
   end

   // x & (x-1) clears the lowest set bit; zero result means one bit at most
   assign valid = (onehot != '0) &&
                  ((onehot & (onehot - COLS'(1))) == '0);

endmodule

// File: rtl/column_drop_engine.sv
// Move-commit unit: validates a column drop, animates the fall
// one row per tick, then commits the piece into the board.
module column_drop_engine
   import score4_pkg::*;
#(
   parameter  int COLS   = DEF_COLS,
   parameter  int ROWS   = DEF_ROWS,
   parameter  int CELL_W = DEF_CELL_W,
   localparam int CW     = (COLS > 1) ? $clog2(COLS) : 1,
   localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1,
   localparam int HW     = $clog2(ROWS + 1)
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                clear,
   input  logic                                play_req,
   input  logic [COLS-1:0]                     play,
   input  logic [CELL_W-1:0]                   player,
   input  logic                                tick,
   output logic                                ready,
   output logic [COLS-1:0][ROWS-1:0][CELL_W-1:0] panel,
   output logic                                fall_active,
   output logic [CW-1:0]                       fall_col,
   output logic [RW-1:0]                       fall_row,
   output logic                                done,
   output logic [RW-1:0]                       done_row,
   output logic                                reject,
   output logic                                board_full
);

   state_t              state;
   state_t              state_nx;
   logic [HW-1:0]       height [COLS];
   logic [CW-1:0]       dec_idx;
   logic                dec_valid;
   logic [HW-1:0]       h_sel;
   logic [RW-1:0]       tgt;
   logic [RW-1:0]       target_q;
   logic [CELL_W-1:0]   player_q;
   logic                accept;
   logic                refuse;
   logic                at_bottom;

   onehot_column_decode #(
      .COLS (COLS)
   ) u_dec (
      .onehot (play),
      .index  (dec_idx),
      .valid  (dec_valid)
   );

   always_comb begin
      h_sel = '0;
      for (int c = 0; c < COLS; c++) begin
         if (dec_idx == CW'(c)) h_sel = height[c];
      end
   end

   // h_sel is below ROWS whenever the move is legal, so it fits RW bits
   assign tgt = RW'(ROWS - 1) - h_sel[RW-1:0];

   assign accept = (state == IDLE) && play_req && dec_valid &&
                   (player != CELL_W'(EMPTY)) &&
                   (h_sel != HW'(ROWS));
   assign refuse = (state == IDLE) && play_req && !accept;

   assign at_bottom   = (fall_row == target_q);
   assign ready       = (state == IDLE);
   assign fall_active = (state == FALL);

   always_comb begin
      board_full = 1'b1;
      for (int c = 0; c < COLS; c++) begin
         if (height[c] != HW'(ROWS)) board_full = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (accept) state_nx = FALL;
         FALL:    if (tick && at_bottom) state_nx = LAND;
         LAND:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (clear) state_nx = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         panel    <= '0;
         fall_col <= '0;
         fall_row <= '0;
         done_row <= '0;
         done     <= 1'b0;
         reject   <= 1'b0;
         target_q <= '0;
         player_q <= '0;
         for (int c = 0; c < COLS; c++) height[c] <= '0;
      end else begin
         done   <= 1'b0;
         reject <= 1'b0;
         if (clear) begin
            panel <= '0;
            for (int c = 0; c < COLS; c++) height[c] <= '0;
         end else begin
            unique case (state)
               IDLE: begin
                  reject <= refuse;
                  if (accept) begin
                     fall_col <= dec_idx;
                     fall_row <= '0;
                     target_q <= tgt;
                     player_q <= player;
                  end
               end
               FALL: begin
                  if (tick && !at_bottom) fall_row <= fall_row + RW'(1);
               end
               LAND: begin
                  for (int c = 0; c < COLS; c++) begin
                     if (fall_col == CW'(c)) begin
                        height[c] <= height[c] + HW'(1);
                        for (int r = 0; r < ROWS; r++) begin
                           if (target_q == RW'(r)) panel[c][r] <= player_q;
                        end
                     end
                  end
                  done_row <= target_q;
                  done     <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_column_drop_engine.sv
// Directed bench for column_drop_engine with a small board model.
module tb_column_drop_engine;

   localparam int COLS   = 7;
   localparam int ROWS   = 6;
   localparam int CELL_W = 2;

   logic clk = 1'b0;
   logic rst, clear, play_req, tick;
   logic [COLS-1:0] play;
   logic [CELL_W-1:0] player;
   logic ready, fall_active, done, reject, board_full;
   logic [COLS-1:0][ROWS-1:0][CELL_W-1:0] panel;
   logic [2:0] fall_col, fall_row, done_row;

   logic [COLS-1:0][ROWS-1:0][CELL_W-1:0] exp_panel;
   int mh [COLS];
   int n_cmp = 0;
   int n_bad = 0;

   column_drop_engine #(
      .COLS   (COLS),
      .ROWS   (ROWS),
      .CELL_W (CELL_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .clear       (clear),
      .play_req    (play_req),
      .play        (play),
      .player      (player),
      .tick        (tick),
      .ready       (ready),
      .panel       (panel),
      .fall_active (fall_active),
      .fall_col    (fall_col),
      .fall_row    (fall_row),
      .done        (done),
      .done_row    (done_row),
      .reject      (reject),
      .board_full  (board_full)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs,
                        input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic full_model();
      for (int c = 0; c < COLS; c++) if (mh[c] != ROWS) return 1'b0;
      return 1'b1;
   endfunction

   task automatic clr_model();
      exp_panel = '0;
      for (int c = 0; c < COLS; c++) mh[c] = 0;
   endtask

   // legal drop with tick held high; starts and ends on a negedge
   task automatic drop(input int c, input logic [1:0] p);
      int lat;
      int row;
      row = ROWS - 1 - mh[c];
      play = 7'(1 << c);
      player = p;
      play_req = 1'b1;
      @(negedge clk);
      play_req = 1'b0;
      check("accept_lat", fall_active, 1);
      lat = 1;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      exp_panel[c][row] = p;
      mh[c]++;
      check("drop_lat", lat, row + 3);
      check("done_row", done_row, row);
      check("panel_at_done", panel, exp_panel);
      check("ready_at_done", ready, 1);
      check("board_full", board_full, full_model());
   endtask

   task automatic try_reject(input string tag, input logic [6:0] pl,
                             input logic [1:0] p);
      play = pl;
      player = p;
      play_req = 1'b1;
      @(negedge clk);
      play_req = 1'b0;
      check({tag, "_reject"}, reject, 1);
      check({tag, "_ready"}, ready, 1);
      check({tag, "_active"}, fall_active, 0);
      @(negedge clk);
      check({tag, "_pulse"}, reject, 0);
      check({tag, "_panel"}, panel, exp_panel);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; clear = 1'b0; play_req = 1'b0;
      play = '0; player = '0; tick = 1'b1;
      clr_model();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_ready", ready, 1);
      check("rst_active", fall_active, 0);
      check("rst_done", done, 0);
      check("rst_reject", reject, 0);
      check("rst_full", board_full, 0);
      check("rst_panel", panel, 0);
      check("rst_col", fall_col, 0);
      check("rst_row", fall_row, 0);
      check("rst_done_row", done_row, 0);

      drop(0, 2'd1);
      for (int i = 0; i < 6; i++) drop(3, (i % 2) ? 2'd2 : 2'd1);
      try_reject("col_full", 7'b0001000, 2'd1);
      try_reject("multi", 7'b0010100, 2'd1);
      try_reject("zero", 7'b0000000, 2'd1);
      try_reject("no_player", 7'b0000010, 2'd0);

      tick = 1'b0;
      play = 7'b0100000; player = 2'd2; play_req = 1'b1;
      @(negedge clk);
      play_req = 1'b0;
      check("slow_active", fall_active, 1);
      check("slow_col", fall_col, 5);
      for (int k = 0; k < 6; k++) begin
         for (int j = 0; j < 3; j++) begin
            check("hold_row", fall_row, k);
            check("hold_active", fall_active, 1);
            play_req = (k == 2 && j == 0);
            play = 7'b1000000; player = 2'd1;
            @(negedge clk);
            play_req = 1'b0;
            check("ignored_req", reject, 0);
         end
         tick = 1'b1;
         check("tick_row", fall_row, k);
         @(negedge clk);
         tick = 1'b0;
      end
      check("land_done", done, 0);
      check("land_active", fall_active, 0);
      @(negedge clk);
      exp_panel[5][5] = 2'd2;
      mh[5]++;
      check("slow_done", done, 1);
      check("slow_done_row", done_row, 5);
      check("slow_panel", panel, exp_panel);
      tick = 1'b1;

      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      clr_model();
      check("clr_panel", panel, 0);
      check("clr_ready", ready, 1);
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            drop(c, ((r * COLS + c) % 2) ? 2'd2 : 2'd1);
      try_reject("full_board", 7'b0000001, 2'd1);

      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      clr_model();
      drop(0, 2'd1);
      tick = 1'b0;
      play = 7'b0000100; player = 2'd2; play_req = 1'b1;
      @(negedge clk);
      play_req = 1'b0;
      check("mid_active", fall_active, 1);
      repeat (2) @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      clr_model();
      check("midclr_ready", ready, 1);
      check("midclr_active", fall_active, 0);
      check("midclr_done", done, 0);
      check("midclr_reject", reject, 0);
      check("midclr_panel", panel, 0);
      @(negedge clk);
      check("midclr_done2", done, 0);

      tick = 1'b1;
      play = 7'b0000010; player = 2'd1;
      play_req = 1'b1; clear = 1'b1;
      @(negedge clk);
      play_req = 1'b0; clear = 1'b0;
      check("clrreq_ready", ready, 1);
      check("clrreq_active", fall_active, 0);
      check("clrreq_reject", reject, 0);
      check("clrreq_panel", panel, 0);
      @(negedge clk);
      check("clrreq_done", done, 0);
      check("clrreq_active2", fall_active, 0);
      drop(4, 2'd2);

      tick = 1'b0;
      play = 7'b0010000; player = 2'd1; play_req = 1'b1;
      @(negedge clk);
      play_req = 1'b0;
      check("pre_rst_col", fall_col, 4);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      check("pre_rst_row", fall_row, 1);
      rst = 1'b1;
      @(negedge clk);
      clr_model();
      check("mrst_ready", ready, 1);
      check("mrst_active", fall_active, 0);
      check("mrst_done", done, 0);
      check("mrst_reject", reject, 0);
      check("mrst_full", board_full, 0);
      check("mrst_col", fall_col, 0);
      check("mrst_row", fall_row, 0);
      check("mrst_done_row", done_row, 0);
      check("mrst_panel", panel, 0);
      rst = 1'b0;
      tick = 1'b1;
      @(negedge clk);
      drop(4, 2'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/column_drop_engine.md
# column_drop_engine

Parametrised, sequential move-commit unit for the Score 4 game core. It owns the board state, accepts a one-hot column selection from the play logic, and rejects illegal moves (non-one-hot selection, empty player code, full column). For a legal move it animates the piece falling one row per `tick`, then commits the piece into the panel. It replaces the purely combinational free-row lookup by keeping per-column fill heights in registers.

## Interface
- Parameters
- `COLS`, default 7: number of columns.
- `ROWS`, default 6: number of rows. Row 0 is the top; row ROWS-1 is the bottom.
- `CELL_W`, default 2: bits per cell. Code 0 means empty.
- Ports
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `clear`  in  1  synchronous board wipe; aborts any move in progress.
- `play_req`  in  1  move request, sampled only while `ready`.
- `play`  in  COLS  one-hot column select.
- `player`  in  CELL_W  piece code to drop; must be nonzero.
- `tick`  in  1  fall-step enable (display rate).
- `ready`  out  1  engine is idle and accepting a request.
- `panel`  out  [COLS][ROWS][CELL_W]  registered board.
- `fall_active`  out  1  a piece is falling.
- `fall_col`  out  $clog2(COLS)  column of the falling piece.
- `fall_row`  out  $clog2(ROWS)  current row of the falling piece.
- `done`  out  1  one-cycle pulse; the piece has been committed.
- `done_row`  out  $clog2(ROWS)  row at which the piece landed.
- `reject`  out  1  one-cycle pulse; the request was illegal.
- `board_full`  out  1  every column holds ROWS pieces.

## Operation
- State kept: `height[COLS]`, each $clog2(ROWS+1) bits, counting 0..ROWS pieces per column. Also the registered panel, latched column, player and target row.
- Landing target for a column is `ROWS-1-height[col]`.
- FSM states: IDLE, FALL, LAND.
- IDLE: `ready`=1.
  - On `play_req`, decode `play`.
  - Reject if `play` is zero or has multiple bits set, if `player`==0, or if `height[col]`==ROWS. A reject pulses `reject` for one cycle and stays in IDLE.
  - Otherwise latch column, player and target, set `fall_row`=0, and go to FALL.
- FALL: `fall_active`=1. On each `tick`:
  - if `fall_row`==target, go to LAND;
  - else increment `fall_row`.
  - The number of ticks needed is target+1.
- LAND (one cycle):
  - write `panel[col][target]`=player;
  - increment `height[col]`;
  - set `done_row`=target;
  - pulse `done`;
  - return to IDLE.
- `board_full` is the AND over all columns of `height==ROWS`.
- `clear` in any state:
  - panel and heights go to 0;
  - state goes to IDLE;
  - `fall_active` goes to 0;
  - `done` and `reject` are not asserted.
  - `clear` overrides a simultaneous `play_req`.
- `rst` has priority over `clear` and has the same effect, plus it zeroes every output register.
- `play_req` outside IDLE is ignored: no queuing, no reject.
- `play`, `player` and `tick` are don't-care outside their sampling states.

## Timing
- Reset values:
  - `panel` all 0, all heights 0, state IDLE;
  - `ready`=1;
  - `fall_active`, `done`, `reject`, `board_full` = 0;
  - `fall_col`, `fall_row`, `done_row` = 0.
- `reject` is asserted in the cycle after the sampled request.
- Accept latency: `fall_active` is high in the cycle after the sampled request.
- Commit latency with `tick` held high: target+3 cycles from request to `done`. An empty column with ROWS=6 gives 8 cycles.
- In the cycle `done` is high, the updated `panel`, incremented height, `board_full` and `ready`=1 are all visible together. A new request may be sampled in that same cycle.
- `tick` low stalls FALL indefinitely. `fall_row` holds its value.

## Structure
- Package `score4_pkg` holds:
  - the state enum (IDLE/FALL/LAND);
  - the `EMPTY` cell code = 0;
  - default `COLS`/`ROWS`/`CELL_W` constants.
- Sub-module `onehot_column_decode`, parametrised on COLS: converts one-hot to index and outputs `valid` (exactly one bit set). It is the only sub-module.
- Everything else is a single FSM plus the height/panel registers in the top module.

## Test plan
- Reset, then `play`=7'b0000001, `player`=1, `tick`=1 → `done` 8 cycles later, `done_row`=5, `panel[0][5]`=1, `height[0]`=1.
- Six legal drops into column 3, then a seventh → `done_row` runs 5,4,3,2,1,0; the seventh gives `reject`=1 for one cycle and leaves the panel unchanged.
- `play`=7'b0010100, then `play`=0, then `player`=0 → three rejects, no state change, `ready` stays 1.
- Legal drop with `tick` pulsed every 4 cycles → `fall_row` steps 0..5 once per tick and holds between ticks. `play_req` during FALL is ignored.
- Fill all 42 cells in alternating players → `board_full` rises in the same cycle as the 42nd `done`. The next request is rejected.
- `clear` asserted mid-FALL, and `clear` together with `play_req` in IDLE → panel all 0, IDLE next cycle, no `done`/`reject`. Repeat with `rst` → same result, plus all outputs zeroed.
